// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector burst reader.
//   SD_SECTOR_BYTES / SD_SECTOR_WORDS : sector size in bytes and in packed 32-bit words
//   burst_state_t                     : burst sequencer FSM states
package sd_pkg;

    localparam int SD_SECTOR_BYTES = 512;
    localparam int SD_SECTOR_WORDS = SD_SECTOR_BYTES / 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_REQ,
        ST_XFER,
        ST_NEXT,
        ST_ERR,
        ST_DONE
    } burst_state_t;

endpackage

// File: rtl/sd_word_fifo.sv
// Synchronous first-word-fall-through FIFO for packed sector words.
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   i_push/data  : write one word; accepted when not full or when popping the same cycle
//   i_pop        : consume the head word; ignored while empty
//   o_data       : head word (0 while empty), o_empty : no word available
//   o_count      : words held, used upstream for the free-space check
//   o_overflow   : a push was dropped because the FIFO was full
module sd_word_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
    assign w_push  = i_push && (!w_full || w_pop);

    // NOTE: the storage array has no reset; the pointers and count alone define
    // which entries are valid, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order or process scheduling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = i_push && !w_push;

endmodule

// File: rtl/sd_sector_burst_reader.sv
// Multi-sector read sequencer: issues one sd_sec_read per sector starting at
// start_sector, packs each 512-byte sector little-endian into 32-bit words and
// buffers them in a FIFO for a valid/ready consumer. A sector is requested only
// when the FIFO can absorb all of it, since the SD side cannot be stalled.
//   start/start_sector/sector_count : burst request (accepted only when idle)
//   busy/done/error                 : burst status (done is a 1-cycle pulse, error is sticky)
//   m_data/m_valid/m_ready          : word stream to the consumer
//   sd_*                            : handshake with the SD sector read engine
module sd_sector_burst_reader #(
    parameter int          FIFO_DEPTH  = 256,
    parameter logic [31:0] ADDR_STEP   = 32'd1,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_sector,
    input  logic [15:0] sector_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        sd_init_done,
    output logic        sd_sec_read,
    output logic [31:0] sd_sec_read_addr,
    input  logic [7:0]  sd_sec_read_data,
    input  logic        sd_sec_read_data_valid,
    input  logic        sd_sec_read_end
);

    import sd_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    burst_state_t r_state;
    burst_state_t w_next;
    logic [31:0]  r_addr;
    logic [15:0]  r_remaining;
    logic [9:0]   r_byte_cnt;
    logic [23:0]  r_pack;
    logic [23:0]  r_tmo_cnt;
    logic         r_done;
    logic         r_error;

    logic          w_accept;
    logic          w_active;
    logic          w_byte_ok;
    logic          w_byte_extra;
    logic          w_push;
    logic [31:0]   w_push_data;
    logic [9:0]    w_byte_cnt_nxt;
    logic          w_tmo;
    logic          w_fifo_empty;
    logic          w_overflow;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_free;

    assign w_accept       = (r_state == ST_IDLE) && start;
    // Bytes are taken in REQ as well: the first byte arrives while the request is still up.
    assign w_active       = (r_state == ST_REQ) || (r_state == ST_XFER);
    assign w_byte_ok      = w_active && sd_sec_read_data_valid && (r_byte_cnt != 10'(SD_SECTOR_BYTES));
    assign w_byte_extra   = w_active && sd_sec_read_data_valid && (r_byte_cnt == 10'(SD_SECTOR_BYTES));
    assign w_push         = w_byte_ok && (r_byte_cnt[1:0] == 2'd3);
    assign w_push_data    = {sd_sec_read_data, r_pack};
    assign w_byte_cnt_nxt = r_byte_cnt + {9'd0, w_byte_ok};
    assign w_tmo          = (TIMEOUT_CYC != 24'd0) && (r_tmo_cnt >= TIMEOUT_CYC - 24'd1);
    assign w_free         = CW'(FIFO_DEPTH) - w_fifo_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next      = r_state;
        sd_sec_read = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (sector_count == 16'd0) ? ST_DONE : ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (sd_init_done && (w_free >= CW'(SD_SECTOR_WORDS))) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ, ST_XFER: begin
                sd_sec_read = (r_state == ST_REQ);
                if (w_byte_extra) begin
                    w_next = ST_ERR;
                end else if (sd_sec_read_end) begin
                    w_next = (w_byte_cnt_nxt == 10'(SD_SECTOR_BYTES)) ? ST_NEXT : ST_ERR;
                end else if (w_tmo) begin
                    w_next = ST_ERR;
                end else if ((r_state == ST_REQ) && sd_sec_read_data_valid) begin
                    w_next = ST_XFER;
                end
            end
            ST_NEXT: begin
                w_next = (r_remaining == 16'd1) ? ST_DONE : ST_WAIT_SPACE;
            end
            ST_ERR:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_byte_cnt  <= '0;
            r_pack      <= '0;
            r_tmo_cnt   <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);

            if (w_accept) begin
                r_error <= 1'b0;
            end else if ((r_state == ST_ERR) || w_overflow) begin
                r_error <= 1'b1;
            end

            if (w_accept) begin
                r_addr      <= start_sector;
                r_remaining <= sector_count;
            end else if (r_state == ST_NEXT) begin
                r_addr      <= r_addr + ADDR_STEP;
                r_remaining <= r_remaining - 16'd1;
            end

            // Leaving REQ/XFER clears the byte count, which also discards a
            // partial word left behind by a failed sector.
            if (w_active) begin
                r_byte_cnt <= w_byte_cnt_nxt;
                r_tmo_cnt  <= r_tmo_cnt + 24'd1;
            end else begin
                r_byte_cnt <= '0;
                r_tmo_cnt  <= '0;
            end

            // Lane 3 never lands in r_pack: it completes the word and is pushed directly.
            if (w_byte_ok) begin
                case (r_byte_cnt[1:0])
                    2'd0:    r_pack[7:0]   <= sd_sec_read_data;
                    2'd1:    r_pack[15:8]  <= sd_sec_read_data;
                    2'd2:    r_pack[23:16] <= sd_sec_read_data;
                    default: ;
                endcase
            end
        end
    end

    sd_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (m_ready),
        .o_data      (m_data),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count),
        .o_overflow  (w_overflow)
    );

    assign busy             = (r_state != ST_IDLE);
    assign done             = r_done;
    assign error            = r_error;
    assign m_valid          = !w_fifo_empty;
    assign sd_sec_read_addr = r_addr;

endmodule
